score_ctrl: RTL and testbench

//  Game score sequencer feeding the score text ROM. Tracks both players' goals as
//  2-digit BCD, runs the IDLE/PLAY/WIN game FSM, detects the winner and drives
//  the ROM's ASCII score fields and winner digit. Sits between game logic (goal

---
 rtl/score_ctrl.sv | 140 ++++++++++++++
 tb/tb_score_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// Game score sequencer: BCD scoring for two players, IDLE/PLAY/WIN flow,
// winner latch and ASCII fields for the score text ROM.
module score_ctrl #(
  parameter int WIN_SCORE   = 10,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        point_my,
  input  logic        point_op,
  output logic [13:0] my_score_ASCII_1,
  output logic [13:0] my_score_ASCII_0,
  output logic [13:0] op_score_ASCII_1,
  output logic [13:0] op_score_ASCII_0,
  output logic [6:0]  number_of_player,
  output logic [1:0]  game_state,
  output logic        win_pulse
);

  // state  | meaning
  // IDLE   | waiting for start; last scores stay displayed
  // PLAY   | goals counted; start restarts the match
  // WIN    | scores frozen, winner shown until start or hold timeout

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10
  } state_t;

  state_t state, state_nx;
  logic [7:0] my_bcd, my_bcd_nx, op_bcd, op_bcd_nx;
  logic [7:0] my_new, op_new;
  logic start_q, my_q, op_q;
  logic start_ev, my_ev, op_ev;
  logic winner, winner_nx;
  logic win_pulse_nx;
  logic [HW-1:0] hold_cnt, hold_nx;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign start_ev = start & ~start_q;
  assign my_ev    = point_my & ~my_q;
  assign op_ev    = point_op & ~op_q;

  assign my_new = my_ev ? bcd_inc(my_bcd) : my_bcd;
  assign op_new = op_ev ? bcd_inc(op_bcd) : op_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      my_bcd    <= 8'h00;
      op_bcd    <= 8'h00;
      start_q   <= 1'b0;
      my_q      <= 1'b0;
      op_q      <= 1'b0;
      winner    <= 1'b0;
      win_pulse <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      my_bcd    <= my_bcd_nx;
      op_bcd    <= op_bcd_nx;
      start_q   <= start;
      my_q      <= point_my;
      op_q      <= point_op;
      winner    <= winner_nx;
      win_pulse <= win_pulse_nx;
      hold_cnt  <= hold_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    my_bcd_nx    = my_bcd;
    op_bcd_nx    = op_bcd;
    winner_nx    = winner;
    win_pulse_nx = 1'b0;
    hold_nx      = hold_cnt;
    case (state)
      S_IDLE: begin
        if (start_ev) begin
          state_nx  = S_PLAY;
          my_bcd_nx = 8'h00;
          op_bcd_nx = 8'h00;
        end
      end
      S_PLAY: begin
        // A restart discards any goal arriving on the same edge.
        if (start_ev) begin
          my_bcd_nx = 8'h00;
          op_bcd_nx = 8'h00;
        end else begin
          my_bcd_nx = my_new;
          op_bcd_nx = op_new;
          if (my_new == WIN_BCD || op_new == WIN_BCD) begin
            state_nx     = S_WIN;
            winner_nx    = (my_new != WIN_BCD);
            win_pulse_nx = 1'b1;
            hold_nx      = '0;
          end
        end
      end
      S_WIN: begin
        if (start_ev) begin
          state_nx  = S_PLAY;
          my_bcd_nx = 8'h00;
          op_bcd_nx = 8'h00;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = S_IDLE;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Digits never exceed 9, so ASCII is just the digit under the 0x3 nibble.
  assign my_score_ASCII_1 = {7'h00, 3'b011, my_bcd[7:4]};
  assign my_score_ASCII_0 = {7'h00, 3'b011, my_bcd[3:0]};
  assign op_score_ASCII_1 = {7'h00, 3'b011, op_bcd[7:4]};
  assign op_score_ASCII_0 = {7'h00, 3'b011, op_bcd[3:0]};

  assign number_of_player = (state == S_WIN) ? (winner ? 7'h32 : 7'h31) : 7'h20;
  assign game_state       = state;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios plus random traffic on two instances
// (short and long match length), compared every cycle against an integer model.
module tb_score_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, pm_a, po_a, start_b, pm_b, po_b;
  logic [13:0] a_my1, a_my0, a_op1, a_op0, b_my1, b_my0, b_op1, b_op0;
  logic [6:0]  a_np, b_np;
  logic [1:0]  a_gs, b_gs;
  logic        a_wp, b_wp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  score_ctrl #(.WIN_SCORE(3), .HOLD_CYCLES(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .point_my(pm_a), .point_op(po_a),
    .my_score_ASCII_1(a_my1), .my_score_ASCII_0(a_my0),
    .op_score_ASCII_1(a_op1), .op_score_ASCII_0(a_op0),
    .number_of_player(a_np), .game_state(a_gs), .win_pulse(a_wp)
  );

  score_ctrl #(.WIN_SCORE(99), .HOLD_CYCLES(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .point_my(pm_b), .point_op(po_b),
    .my_score_ASCII_1(b_my1), .my_score_ASCII_0(b_my0),
    .op_score_ASCII_1(b_op1), .op_score_ASCII_0(b_op0),
    .number_of_player(b_np), .game_state(b_gs), .win_pulse(b_wp)
  );

  // st: 0 idle, 1 play, 2 win; scores as plain integers
  typedef struct packed {
    int st;
    int my;
    int op;
    bit winner;
    int hold;
    bit ps;
    bit pa;
    bit pb;
    bit pulse;
  } model_t;

  model_t ma, mb;

  function automatic model_t mreset();
    model_t r;
    r = '0;
    return r;
  endfunction

  function automatic model_t mstep(model_t m, bit s, bit a, bit b, int ws, int hc);
    model_t n;
    bit se, ae, be;
    n  = m;
    se = s && !m.ps;
    ae = a && !m.pa;
    be = b && !m.pb;
    n.ps = s; n.pa = a; n.pb = b;
    n.pulse = 1'b0;
    if (m.st == 0) begin
      if (se) begin n.st = 1; n.my = 0; n.op = 0; end
    end else if (m.st == 1) begin
      if (se) begin
        n.my = 0; n.op = 0;
      end else begin
        if (ae && n.my < 99) n.my = n.my + 1;
        if (be && n.op < 99) n.op = n.op + 1;
        if (n.my == ws || n.op == ws) begin
          n.st = 2; n.winner = (n.my != ws); n.hold = 0; n.pulse = 1'b1;
        end
      end
    end else begin
      if (se) begin n.st = 1; n.my = 0; n.op = 0; end
      else if (m.hold == hc - 1) n.st = 0;
      else n.hold = m.hold + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_dut(input string tag, input model_t m,
                           input logic [13:0] my1, my0, op1, op0,
                           input logic [6:0] np, input logic [1:0] gs, input logic wp);
    chk({tag, ".my1"}, 32'(my1), 32'h30 + 32'(m.my / 10));
    chk({tag, ".my0"}, 32'(my0), 32'h30 + 32'(m.my % 10));
    chk({tag, ".op1"}, 32'(op1), 32'h30 + 32'(m.op / 10));
    chk({tag, ".op0"}, 32'(op0), 32'h30 + 32'(m.op % 10));
    chk({tag, ".np"},  32'(np),  (m.st == 2) ? (m.winner ? 32'h32 : 32'h31) : 32'h20);
    chk({tag, ".gs"},  32'(gs),  32'(m.st));
    chk({tag, ".wp"},  32'(wp),  32'(m.pulse));
  endtask

  task automatic check_both();
    check_dut("a", ma, a_my1, a_my0, a_op1, a_op0, a_np, a_gs, a_wp);
    check_dut("b", mb, b_my1, b_my0, b_op1, b_op0, b_np, b_gs, b_wp);
  endtask

  task automatic cyc(input bit sa, input bit pa, input bit oa,
                     input bit sb, input bit pb, input bit ob);
    @(negedge clk);
    start_a = sa; pm_a = pa; po_a = oa;
    start_b = sb; pm_b = pb; po_b = ob;
    @(posedge clk);
    ma = mstep(ma, sa, pa, oa, 3, 20);
    mb = mstep(mb, sb, pb, ob, 99, 20);
    #1;
    check_both();
  endtask

  task automatic cyc_a(input bit sa, input bit pa, input bit oa);
    cyc(sa, pa, oa, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc_b(input bit sb, input bit pb, input bit ob);
    cyc(1'b0, 1'b0, 1'b0, sb, pb, ob);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start_a = 0; pm_a = 0; po_a = 0; start_b = 0; pm_b = 0; po_b = 0;
    ma = mreset();
    mb = mreset();
    #1;
    check_both();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; pm_a = 0; po_a = 0; start_b = 0; pm_b = 0; po_b = 0;
    ma = mreset();
    mb = mreset();
    #23;
    check_both();
    chk("rst_my0", 32'(a_my0), 32'h30);
    chk("rst_np",  32'(a_np),  32'h20);
    @(negedge clk);
    rst_n = 1'b1;

    // Start, then three P1 goals -> win with P1
    cyc_a(1, 0, 0);
    cyc_a(0, 0, 0);
    cyc_a(0, 1, 0);
    chk("t2_my0_1", 32'(a_my0), 32'h31);
    cyc_a(0, 0, 0);
    cyc_a(0, 1, 0);
    chk("t2_my0_2", 32'(a_my0), 32'h32);
    cyc_a(0, 0, 0);
    cyc_a(0, 1, 0);
    chk("t2_my0_3", 32'(a_my0), 32'h33);
    chk("t2_gs",    32'(a_gs),  32'h2);
    chk("t2_wp",    32'(a_wp),  32'h1);
    chk("t2_np",    32'(a_np),  32'h31);
    cyc_a(0, 0, 0);
    chk("t2_wp_off", 32'(a_wp), 32'h0);

    // Points in WIN are ignored; timeout back to IDLE 20 cycles after entry
    for (int i = 0; i < 18; i++) cyc_a(0, i[0], i[1]);
    chk("t5_still_win", 32'(a_gs), 32'h2);
    chk("t5_my0", 32'(a_my0), 32'h33);
    cyc_a(0, 0, 0);
    chk("t5_idle", 32'(a_gs), 32'h0);
    chk("t5_np",   32'(a_np), 32'h20);

    // Held point counts once
    cyc_a(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc_a(0, 0, 1);
    cyc_a(0, 0, 0);
    chk("t3_op0", 32'(a_op0), 32'h31);
    chk("t3_op1", 32'(a_op1), 32'h30);

    // Reach P1=02 then abort with async reset
    cyc_a(0, 1, 0); cyc_a(0, 0, 0);
    cyc_a(0, 1, 0); cyc_a(0, 0, 0);
    chk("t1_pre", 32'(a_my0), 32'h32);
    do_reset();
    chk("t1_gs",  32'(a_gs),  32'h0);
    chk("t1_my0", 32'(a_my0), 32'h30);
    chk("t1_op0", 32'(a_op0), 32'h30);

    // Tie at WIN_SCORE on the same edge -> P1 wins
    cyc_a(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc_a(0, 1, 1);
      cyc_a(0, 0, 0);
    end
    cyc_a(0, 1, 1);
    chk("t4_my0", 32'(a_my0), 32'h33);
    chk("t4_op0", 32'(a_op0), 32'h33);
    chk("t4_gs",  32'(a_gs),  32'h2);
    chk("t4_np",  32'(a_np),  32'h31);
    cyc_a(1, 0, 0);
    chk("t4_restart_gs", 32'(a_gs), 32'h1);
    chk("t4_restart_my", 32'(a_my0), 32'h30);

    // Long match: BCD carry and win at 99, then restart from WIN
    cyc_b(1, 0, 0);
    for (int i = 0; i < 9; i++) begin cyc_b(0, 1, 0); cyc_b(0, 0, 0); end
    chk("t6_09_t", 32'(b_my1), 32'h30);
    chk("t6_09_u", 32'(b_my0), 32'h39);
    cyc_b(0, 1, 0); cyc_b(0, 0, 0);
    chk("t6_10_t", 32'(b_my1), 32'h31);
    chk("t6_10_u", 32'(b_my0), 32'h30);
    for (int i = 0; i < 89; i++) begin cyc_b(0, 1, 0); cyc_b(0, 0, 0); end
    chk("t6_win", 32'(b_gs), 32'h2);
    cyc_b(1, 0, 0);
    chk("t6_play", 32'(b_gs),  32'h1);
    chk("t6_my0",  32'(b_my0), 32'h30);
    chk("t6_op1",  32'(b_op1), 32'h30);

    // Random traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      cyc($urandom_range(15) == 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
          $urandom_range(31) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
